mode_router: RTL and testbench
==============================

MODE_ROUTER -- requirements
Module: mode_router

Interface
REQ-001 Parameter N_MODES, default 4, number of display/control modes (2..8).
REQ-002 Parameter SW_W, default 4, number of debounced push-switch inputs.
REQ-003 Parameter CHAR_W, default 8, width of one LCD character code.
REQ-004 Parameter IDX_W, default 5, width of the LCD character index.
REQ-005 Parameter LAST_IDX, default 31, index value marking the last character of an LCD frame.
REQ-006 Parameter TIMEOUT_S, default 30, idle seconds before auto-return to mode 0 (1..255).
REQ-007 clk  in  1  system clock; all logic is single-clock.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 en_1hz  in  1  one-cycle 1 Hz enable strobe.
REQ-010 mode_sel  in  N_MODES  one-hot mode request from the DIP switches; bit k requests mode k.
REQ-011 sw_in  in  SW_W  debounced switch levels, high = pressed.
REQ-012 index_char  in  IDX_W  character index currently requested by the LCD driver.
REQ-013 data_in  in  N_MODES*CHAR_W  character from each mode; mode k occupies bits [k*CHAR_W +: CHAR_W].
REQ-014 data_char  out  CHAR_W  registered character for the LCD driver.
REQ-015 sw_pulse  out  N_MODES*SW_W  one-cycle press pulses; lane k is bits [k*SW_W +: SW_W].
REQ-016 mode  out  clog2(N_MODES)  currently active mode index.
REQ-017 mode_chg  out  1  one-cycle pulse in the cycle after the active mode changes.

Function
REQ-018 Request decode: exactly one mode_sel bit set requests that mode; zero bits or more than one bit set request mode 0.
REQ-019 Press detect: sw_in is registered once; a 0->1 transition on bit j produces a one-cycle pulse on bit j of the active mode's lane, one cycle after the sw_in edge is sampled; all other lanes stay 0.
REQ-020 State machine states: IDLE and PENDING.
REQ-021 In IDLE, a decoded request different from the active mode latches that request as pending and moves to PENDING.
REQ-022 In PENDING, the pending value follows the decoded request every cycle.
REQ-023 In PENDING, if the decoded request equals the active mode, return to IDLE with no change and no mode_chg.
REQ-024 In PENDING, when index_char == LAST_IDX, set active mode to pending, assert mode_chg in the next cycle, and return to IDLE; the LCD frame therefore never mixes two modes.
REQ-025 All press pulses are suppressed while in PENDING and in the switching cycle; presses are dropped, not queued.
REQ-026 data_char <= data_in slice of the active mode, one-cycle latency; the new mode's data appears starting with the character after LAST_IDX.
REQ-027 A 1->0 transition or a held level on sw_in never produces a pulse.

Reset
REQ-028 While rst is high, and immediately on its assertion: data_char = 0, sw_pulse = 0, mode = 0, mode_chg = 0, state = IDLE, the sw_in register is 0, and the timeout counter and override flag are 0.
REQ-029 Reset asserted in PENDING abandons the switch; after release, a request still differing from mode 0 re-enters PENDING normally.
REQ-030 A switch held high through reset release produces one pulse, because the sw_in register is 0.

Configuration
REQ-031 Macro MODE_ROUTER_TIMEOUT_EN: when defined, an 8-bit counter increments on en_1hz while the active mode is nonzero.
REQ-032 With the macro defined, the counter clears on any press edge, on any mode change, and whenever the active mode is 0.
REQ-033 With the macro defined, when the counter reaches TIMEOUT_S an override flag sets; while it is set the decoded request is forced to 0 and the REQ-024 switch rules apply.
REQ-034 With the macro defined, the override flag clears when mode_sel changes value.
REQ-035 Without the macro, no counter or override logic exists, en_1hz is unused, and behaviour equals the macro-defined case with an infinite timeout.

Verification
REQ-036 Reset, mode_sel=0001, data_in slice0=0x41, index_char cycling 0..31 -> data_char=0x41 one cycle after release, mode=0, sw_pulse=0.
REQ-037 mode_sel 0001->0100 at index_char=10 -> mode remains 0 until index_char=31, then mode=2, mode_chg is a single pulse, data_char = slice2 from index 0.
REQ-038 sw_in[1] rising in mode 2 -> sw_pulse bit 9 high exactly 1 cycle; a press while PENDING -> no pulse on any lane.
REQ-039 mode_sel 0001->0010->0001 within one frame -> no mode change and no mode_chg; mode_sel=0110 -> switches to mode 0 at frame end.
REQ-040 With MODE_ROUTER_TIMEOUT_EN and TIMEOUT_S=3, mode 1, no presses, 3 en_1hz strobes -> mode=0 at the next LAST_IDX; toggling mode_sel back to 0010 -> mode=1.

Source files
------------

// File: rtl/mode_router.sv
// Routes the active mode's LCD character and switch presses; mode changes only at LCD frame end.
// Latency: data_char, sw_pulse and mode_chg are registered, one cycle after their inputs.
// Presses are dropped while a switch is pending. Optional idle timeout: MODE_ROUTER_TIMEOUT_EN.
module mode_router #(
  parameter int N_MODES   = 4,
  parameter int SW_W      = 4,
  parameter int CHAR_W    = 8,
  parameter int IDX_W     = 5,
  parameter int LAST_IDX  = 31,
  parameter int TIMEOUT_S = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_1hz,
  input  logic [N_MODES-1:0]           mode_sel,
  input  logic [SW_W-1:0]              sw_in,
  input  logic [IDX_W-1:0]             index_char,
  input  logic [N_MODES*CHAR_W-1:0]    data_in,
  output logic [CHAR_W-1:0]            data_char,
  output logic [N_MODES*SW_W-1:0]      sw_pulse,
  output logic [$clog2(N_MODES)-1:0]   mode,
  output logic                         mode_chg
);

  localparam int MW = $clog2(N_MODES);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [MW-1:0]             mode_q, mode_d;
  logic [MW-1:0]             pend_q, pend_d;
  logic [MW-1:0]             req_raw, req;
  int                        sel_hits;
  logic                      switch_now;
  logic [SW_W-1:0]           sw_q, rise;
  logic [N_MODES*SW_W-1:0]   pulse_q, pulse_d;
  logic [CHAR_W-1:0]         data_q, data_d;
  logic                      chg_q;

  assign rise = sw_in & ~sw_q;

  // Decode the DIP one-hot request; anything but a single set bit means mode 0.
  always_comb begin
    req_raw  = '0;
    sel_hits = 0;
    for (int k = 0; k < N_MODES; k++) begin
      if (mode_sel[k]) begin
        sel_hits = sel_hits + 1;
        req_raw  = MW'(k);
      end
    end
    if (sel_hits != 1) req_raw = '0;
  end

`ifdef MODE_ROUTER_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
  logic                ovr_q, ovr_d;
  logic [N_MODES-1:0]  sel_q;

  assign req = ovr_q ? '0 : req_raw;

  // Idle-seconds counter; reaching the limit forces the request to mode 0 until mode_sel moves.
  always_comb begin
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if ((|rise) || switch_now || (mode_q == '0)) begin
      cnt_d = '0;
    end else if (en_1hz && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q + 8'd1 == 8'(TIMEOUT_S)) ovr_d = 1'b1;
    end
    if (mode_sel != sel_q) ovr_d = 1'b0;
  end

  // Timeout state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovr_q <= 1'b0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      sel_q <= mode_sel;
    end
  end
`else
  logic unused_en;
  assign unused_en = en_1hz;
  assign req       = req_raw;
`endif

  // Switch FSM: hold a differing request until the last character of the frame.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    mode_d     = mode_q;
    switch_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != mode_q) begin
          pend_d  = req;
          state_d = PENDING;
        end
      end
      PENDING: begin
        pend_d = req;
        if (req == mode_q) begin
          state_d = IDLE;
        end else if (index_char == IDX_W'(LAST_IDX)) begin
          mode_d     = pend_q;
          switch_now = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Character mux and press routing to the active lane; presses vanish outside IDLE.
  always_comb begin
    data_d  = '0;
    pulse_d = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (mode_q == MW'(k)) begin
        data_d = data_in[k*CHAR_W +: CHAR_W];
        if (state_q == IDLE) pulse_d[k*SW_W +: SW_W] = rise;
      end
    end
  end

  // Core state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      pend_q  <= '0;
      sw_q    <= '0;
      pulse_q <= '0;
      data_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      sw_q    <= sw_in;
      pulse_q <= pulse_d;
      data_q  <= data_d;
      chg_q   <= switch_now;
    end
  end

  assign data_char = data_q;
  assign sw_pulse  = pulse_q;
  assign mode      = mode_q;
  assign mode_chg  = chg_q;

endmodule

// File: tb/tb_mode_router.sv
// Self-checking bench for mode_router: directed scenarios plus randomized traffic.
// Reference model tracks active mode, frame-end switching and press edges per clock.
// Optional timeout scenario is selected by MODE_ROUTER_TIMEOUT_EN.
module tb_mode_router;

  localparam int TOS = 3;
  localparam logic [31:0] DATA = 32'h44434241;

  logic        clk = 1'b0;
  logic        rst, en_1hz;
  logic [3:0]  mode_sel, sw_in;
  logic [4:0]  index_char;
  logic [31:0] data_in;
  logic [7:0]  data_char;
  logic [15:0] sw_pulse;
  logic [1:0]  mode;
  logic        mode_chg;

  mode_router #(.N_MODES(4), .SW_W(4), .CHAR_W(8), .IDX_W(5), .LAST_IDX(31), .TIMEOUT_S(TOS)) dut (
    .clk(clk), .rst(rst), .en_1hz(en_1hz), .mode_sel(mode_sel), .sw_in(sw_in),
    .index_char(index_char), .data_in(data_in), .data_char(data_char),
    .sw_pulse(sw_pulse), .mode(mode), .mode_chg(mode_chg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_mode, m_target;
  bit          m_wait;
  logic [3:0]  m_sw;
  logic [7:0]  e_data;
  logic [15:0] e_pulse;
  bit          e_chg;
`ifdef MODE_ROUTER_TIMEOUT_EN
  int          m_cnt;
  bit          m_ovr;
  logic [3:0]  m_sel;
`endif

  logic [26:0] dut_vec;
  assign dut_vec = {data_char, sw_pulse, mode, mode_chg};

  function automatic logic [26:0] exp_vec();
    return {e_data, e_pulse, 2'(m_mode), e_chg};
  endfunction

  function automatic int decode(input logic [3:0] s);
    if ($countones(s) != 1) return 0;
    for (int k = 0; k < 4; k++) if (s[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_target = 0; m_wait = 0; m_sw = '0;
    e_data = '0; e_pulse = '0; e_chg = 0;
`ifdef MODE_ROUTER_TIMEOUT_EN
    m_cnt = 0; m_ovr = 0; m_sel = '0;
`endif
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int         req, old_mode;
    logic [3:0] rise;
    bit         sw_now;
    req = decode(mode_sel);
`ifdef MODE_ROUTER_TIMEOUT_EN
    if (m_ovr) req = 0;
`endif
    rise     = sw_in & ~m_sw;
    old_mode = m_mode;
    e_pulse  = '0;
    if (!m_wait) e_pulse[old_mode*4 +: 4] = rise;
    e_data   = data_in[old_mode*8 +: 8];
    sw_now   = 0;
    if (!m_wait) begin
      if (req != m_mode) begin m_wait = 1; m_target = req; end
    end else if (req == m_mode) begin
      m_wait = 0;
    end else begin
      if (index_char == 5'd31) begin m_mode = m_target; sw_now = 1; m_wait = 0; end
      m_target = req;
    end
    e_chg = sw_now;
`ifdef MODE_ROUTER_TIMEOUT_EN
    if ((|rise) || sw_now || old_mode == 0) m_cnt = 0;
    else if (en_1hz && m_cnt < 255) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == TOS) m_ovr = 1;
    end
    if (mode_sel != m_sel) m_ovr = 0;
    m_sel = mode_sel;
`endif
    m_sw = sw_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    index_char = index_char + 5'd1;
  endtask

  task automatic run_to(input logic [4:0] idx);
    for (int i = 0; i < 40 && index_char != idx; i++) tick();
  endtask

  task automatic test_reset();
    rst = 0; en_1hz = 0; mode_sel = 4'b0001; sw_in = '0; index_char = '0; data_in = DATA;
    #2 rst = 1;
    #1;
    checks++;
    if (dut_vec !== 27'd0) begin errors++; $display("FAIL reset_async: got %h required 0", dut_vec); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 27'd0) begin errors++; $display("FAIL reset_held: got %h required 0", dut_vec); end
    rst = 0;
    model_reset();
    tick();
    checks++;
    if (data_char !== 8'h41) begin errors++; $display("FAIL reset_first_char: got %h required 41", data_char); end
    checks++;
    if (mode !== 2'd0 || sw_pulse !== 16'd0) begin
      errors++; $display("FAIL reset_mode_pulse: got mode %0d pulse %h required 0 0", mode, sw_pulse);
    end
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_frame: got %h required %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_switch();
    int cur;
    run_to(5'd10);
    mode_sel = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      cur = index_char;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL switch_model: got %h required %h", dut_vec, exp_vec()); end
      checks++;
      if (cur != 31 && (mode !== 2'd0 || mode_chg !== 1'b0)) begin
        errors++; $display("FAIL switch_early: got mode %0d chg %b required 0 0 at idx %0d", mode, mode_chg, cur);
      end else if (cur == 31 && (mode !== 2'd2 || mode_chg !== 1'b1)) begin
        errors++; $display("FAIL switch_at_last: got mode %0d chg %b required 2 1", mode, mode_chg);
      end
      if (cur == 31) break;
    end
    tick();
    checks++;
    if (mode_chg !== 1'b0 || data_char !== 8'h43) begin
      errors++; $display("FAIL switch_after: got chg %b char %h required 0 43", mode_chg, data_char);
    end
  endtask

  task automatic test_press();
    sw_in = 4'b0010;
    tick();
    checks++;
    if (sw_pulse !== 16'h0200) begin errors++; $display("FAIL press_lane2: got %h required 0200", sw_pulse); end
    tick();
    checks++;
    if (sw_pulse !== 16'h0000) begin errors++; $display("FAIL press_held: got %h required 0000", sw_pulse); end
    sw_in = 4'b0000;
    tick();
    checks++;
    if (sw_pulse !== 16'h0000) begin errors++; $display("FAIL press_release: got %h required 0000", sw_pulse); end
    mode_sel = 4'b0001;
    tick();
    sw_in = 4'b0100;
    tick();
    checks++;
    if (sw_pulse !== 16'h0000) begin errors++; $display("FAIL press_pending: got %h required 0000", sw_pulse); end
    sw_in = 4'b0000;
    run_to(5'd31);
    sw_in = 4'b1000;
    tick();
    checks++;
    if (sw_pulse !== 16'h0000 || mode !== 2'd0 || mode_chg !== 1'b1) begin
      errors++; $display("FAIL press_switch_cycle: got pulse %h mode %0d chg %b required 0000 0 1", sw_pulse, mode, mode_chg);
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL press_model: got %h required %h", dut_vec, exp_vec()); end
    sw_in = 4'b0000;
    tick();
  endtask

  task automatic test_cancel();
    mode_sel = 4'b0010;
    tick();
    mode_sel = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (mode !== 2'd0 || mode_chg !== 1'b0) begin
        errors++; $display("FAIL cancel_nochange: got mode %0d chg %b required 0 0", mode, mode_chg);
      end
    end
    mode_sel = 4'b0010;
    repeat (34) tick();
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL cancel_to_mode1: got %0d required 1", mode); end
    mode_sel = 4'b0110;
    repeat (34) tick();
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL multihot_to_mode0: got %0d required 0", mode); end
  endtask

  task automatic test_timeout();
    mode_sel = 4'b0010;
    repeat (34) tick();
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL timeout_setup: got %0d required 1", mode); end
    for (int s = 0; s < TOS; s++) begin
      en_1hz = 1; tick(); en_1hz = 0; tick();
    end
    repeat (34) tick();
`ifdef MODE_ROUTER_TIMEOUT_EN
    checks++;
    if (mode !== 2'd0) begin errors++; $display("FAIL timeout_return: got %0d required 0", mode); end
    mode_sel = 4'b0001;
    tick();
    mode_sel = 4'b0010;
    repeat (34) tick();
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL timeout_reselect: got %0d required 1", mode); end
`else
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL no_timeout_hold: got %0d required 1", mode); end
    repeat (34) tick();
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL no_timeout_hold2: got %0d required 1", mode); end
`endif
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL timeout_model: got %h required %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_held_reset();
    mode_sel = 4'b0100;
    tick();
    sw_in = 4'b1000;
    @(negedge clk);
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    tick();
    checks++;
    if (sw_pulse !== 16'h0008) begin errors++; $display("FAIL held_reset_pulse: got %h required 0008", sw_pulse); end
    tick();
    checks++;
    if (sw_pulse !== 16'h0000) begin errors++; $display("FAIL held_reset_once: got %h required 0000", sw_pulse); end
    repeat (34) tick();
    checks++;
    if (mode !== 2'd2) begin errors++; $display("FAIL reset_pending_retry: got %0d required 2", mode); end
    sw_in = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 3))
          0:       mode_sel = 4'b0000;
          1:       mode_sel = 4'($urandom);
          default: mode_sel = 4'b0001 << $urandom_range(0, 3);
        endcase
      end
      if ($urandom_range(0, 7) == 0) sw_in[$urandom_range(0, 3)] = ~sw_in[$urandom_range(0, 3)];
      en_1hz  = ($urandom_range(0, 5) == 0);
      data_in = $urandom;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_cycle%0d: got %h required %h", i, dut_vec, exp_vec()); end
    end
    en_1hz = 0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_press();
    test_cancel();
    test_timeout();
    test_held_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
